// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 burst read master: fetches a word range into a FWFT FIFO and streams it
// out on a valid/next lane, with sticky done/error reporting (error = state[4]).
module painterengine_gpu_dma_reader #(
  parameter int PARAM_MAX_BURST  = 16,
  parameter int PARAM_FIFO_DEPTH = 32,
  parameter int PARAM_TIMEOUT    = 256
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [2:0]  o_wire_error_type,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic        o_wire_M_AXI_ARID,
  output logic [31:0] o_wire_M_AXI_ARADDR,
  output logic [7:0]  o_wire_M_AXI_ARLEN,
  output logic [2:0]  o_wire_M_AXI_ARSIZE,
  output logic [1:0]  o_wire_M_AXI_ARBURST,
  output logic        o_wire_M_AXI_ARLOCK,
  output logic [3:0]  o_wire_M_AXI_ARCACHE,
  output logic [2:0]  o_wire_M_AXI_ARPROT,
  output logic [3:0]  o_wire_M_AXI_ARQOS,
  output logic        o_wire_M_AXI_ARVALID,
  input  logic        i_wire_M_AXI_ARREADY,
  input  logic        i_wire_M_AXI_RID,
  input  logic [31:0] i_wire_M_AXI_RDATA,
  input  logic [1:0]  i_wire_M_AXI_RRESP,
  input  logic        i_wire_M_AXI_RLAST,
  input  logic        i_wire_M_AXI_RVALID,
  output logic        o_wire_M_AXI_RREADY,
  output logic [4:0]  o_wire_debug_state
);

  localparam int AW = $clog2(PARAM_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PARAM_TIMEOUT) + 1;

  typedef enum logic [4:0] {
    S_IDLE        = 5'h00,
    S_CHECK       = 5'h01,
    S_CALC        = 5'h02,
    S_ADDR        = 5'h03,
    S_DATA        = 5'h04,
    S_DRAIN       = 5'h05,
    S_DONE        = 5'h06,
    S_ALIGN_ERR   = 5'h11,
    S_LEN_ERR     = 5'h12,
    S_TIMEOUT_ERR = 5'h13,
    S_RESP_ERR    = 5'h14,
    S_LAST_ERR    = 5'h15
  } state_t;

  state_t state, state_next;

  logic [31:0]   cur_addr, job_length, offset;
  logic [8:0]    burst, beat;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   fifo_mem [PARAM_FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fifo_count, fifo_free;

  logic [31:0] remaining, offset_sum;
  logic [10:0] boundary_beats;
  logic [8:0]  burst_calc;
  logic        ar_fire, r_fire, beat_is_last, tmo_hit;
  logic        push, pop, flush;
  logic        unused_inputs;

  assign unused_inputs = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0]};

  // Valid/ready: a transfer happens on any rising edge where both are high.
  // ARVALID is only driven in ADDR, RREADY only in DATA, so they never overlap.
  assign ar_fire      = (state == S_ADDR) && i_wire_M_AXI_ARREADY;
  assign r_fire       = (state == S_DATA) && i_wire_M_AXI_RVALID;
  assign beat_is_last = (beat == burst - 9'd1);
  assign tmo_hit      = (tmo_cnt == TW'(PARAM_TIMEOUT - 1));
  assign offset_sum   = offset + {23'b0, burst};

  // Burst never exceeds remaining words, the max burst, or the next 4KB page.
  always_comb begin
    remaining      = job_length - offset;
    boundary_beats = 11'((13'h1000 - {1'b0, cur_addr[11:0]}) >> 2);
    burst_calc     = 9'(PARAM_MAX_BURST);
    if (remaining < 32'(PARAM_MAX_BURST)) burst_calc = remaining[8:0];
    if (boundary_beats < {2'b0, burst_calc}) burst_calc = boundary_beats[8:0];
  end

  assign fifo_free = CW'(PARAM_FIFO_DEPTH) - fifo_count;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_wire_start) state_next = S_CHECK;
      S_CHECK: begin
        if (cur_addr[1:0] != 2'b00)  state_next = S_ALIGN_ERR;
        else if (job_length == 32'd0) state_next = S_LEN_ERR;
        else                          state_next = S_CALC;
      end
      S_CALC:  if (32'(fifo_free) >= 32'(burst_calc)) state_next = S_ADDR;
      S_ADDR: begin
        if (ar_fire)      state_next = S_DATA;
        else if (tmo_hit) state_next = S_TIMEOUT_ERR;
      end
      S_DATA: begin
        if (r_fire) begin
          if (i_wire_M_AXI_RRESP[1])                 state_next = S_RESP_ERR;
          else if (i_wire_M_AXI_RLAST != beat_is_last) state_next = S_LAST_ERR;
          else if (beat_is_last)
            state_next = (offset_sum < job_length) ? S_CALC : S_DRAIN;
        end else if (tmo_hit) begin
          state_next = S_TIMEOUT_ERR;
        end
      end
      S_DRAIN: if (fifo_count == '0) state_next = S_DONE;
      S_DONE, S_ALIGN_ERR, S_LEN_ERR, S_TIMEOUT_ERR, S_RESP_ERR, S_LAST_ERR:
        if (!i_wire_start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state <= S_IDLE;
    else                state <= state_next;
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      cur_addr   <= '0;
      job_length <= '0;
      offset     <= '0;
      burst      <= '0;
      beat       <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_wire_start) begin
          cur_addr   <= i_wire_address;
          job_length <= i_wire_length;
          offset     <= '0;
        end
        S_CALC: begin
          burst   <= burst_calc;
          beat    <= '0;
          tmo_cnt <= '0;
        end
        S_ADDR: tmo_cnt <= ar_fire ? '0 : tmo_cnt + TW'(1);
        S_DATA: begin
          if (r_fire) begin
            beat    <= beat + 9'd1;
            tmo_cnt <= '0;
            if (beat_is_last) begin
              offset   <= offset_sum;
              cur_addr <= cur_addr + {21'b0, burst, 2'b00};
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // FWFT FIFO; cleared on the edge that enters an error state.
  assign push  = r_fire;
  assign pop   = o_wire_data_valid && i_wire_data_next;
  assign flush = state_next[4] && !state[4];

  always_ff @(posedge i_wire_clock) begin
    if (push) fifo_mem[wptr] <= i_wire_M_AXI_RDATA;
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign o_wire_data       = fifo_mem[rptr];
  assign o_wire_data_valid = (fifo_count != '0) && !state[4];
  assign o_wire_done       = (state == S_DONE);
  assign o_wire_error      = state[4];
  assign o_wire_error_type = state[4] ? state[2:0] : 3'd0;
  assign o_wire_debug_state = state;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = cur_addr;
  assign o_wire_M_AXI_ARLEN   = 8'(burst - 9'd1);
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = (state == S_ADDR);
  assign o_wire_M_AXI_RREADY  = (state == S_DATA);

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: table of jobs against a burst-splitting
// reference model and a memory-backed AXI slave, plus stall/reset sequences.
module tb_painterengine_gpu_dma_reader;

  logic        clk = 1'b0;
  logic        resetn, start, next;
  logic [31:0] address, length;
  logic        done_o, error_o, dvalid_o;
  logic [2:0]  err_type_o;
  logic [31:0] data_o;
  logic        arid_o, arlock_o, arvalid_o, rready_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o, arprot_o;
  logic [1:0]  arburst_o;
  logic [3:0]  arcache_o, arqos_o;
  logic [4:0]  dbg_state_o;
  logic        arready, rvalid, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_start(start),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done_o), .o_wire_error(error_o), .o_wire_error_type(err_type_o),
    .o_wire_data(data_o), .o_wire_data_valid(dvalid_o), .i_wire_data_next(next),
    .o_wire_M_AXI_ARID(arid_o), .o_wire_M_AXI_ARADDR(araddr_o), .o_wire_M_AXI_ARLEN(arlen_o),
    .o_wire_M_AXI_ARSIZE(arsize_o), .o_wire_M_AXI_ARBURST(arburst_o), .o_wire_M_AXI_ARLOCK(arlock_o),
    .o_wire_M_AXI_ARCACHE(arcache_o), .o_wire_M_AXI_ARPROT(arprot_o), .o_wire_M_AXI_ARQOS(arqos_o),
    .o_wire_M_AXI_ARVALID(arvalid_o), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(1'b0), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready_o),
    .o_wire_debug_state(dbg_state_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          ar_mode;    // 0 always ready, 1 random, 2 never
    int          next_mode;  // 0 always, 1 random, 2 held low
    int          resp_beat;  // job beat returning SLVERR, -1 none
    int          last_beat;  // job beat with forced RLAST, -1 none
    logic [2:0]  exp_type;   // 0 = expect done
  } vec_t;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_ar[$];
  logic [63:0] sl_q[$];
  int r_beat = 0, job_beat = 0, beats_seen = 0;
  int ar_mode = 0, next_mode = 0, inj_resp = -1, inj_last = -1;
  bit arvalid_seen = 0, overlap = 0;

  logic        s_arvalid = 0, s_arready = 0, s_rvalid = 0, s_rready = 0, s_dvalid = 0, s_next = 0;
  logic [31:0] s_araddr = 0, s_data = 0;
  logic [7:0]  s_arlen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: split the range into bursts of <=16 words that stay inside a 4KB page.
  task automatic build_model(input logic [31:0] addr, input logic [31:0] len);
    longint a, rem, b, bnd;
    exp_q.delete();
    exp_ar.delete();
    a = longint'(addr);
    rem = longint'(len);
    while (rem > 0) begin
      b = (rem > 16) ? 16 : rem;
      bnd = (4096 - (a % 4096)) / 4;
      if (b > bnd) b = bnd;
      exp_ar.push_back({a[31:0], b[31:0]});
      for (longint i = 0; i < b; i++) exp_q.push_back(mem_word(32'(a + 4 * i)));
      a = (a + 4 * b) % 64'h1_0000_0000;
      rem -= b;
    end
  endtask

  // AXI slave, consumer and monitors; handshakes are judged from the values
  // captured at the previous falling edge, which were stable across the rising edge.
  always @(negedge clk) begin
    logic [63:0] got, want;
    logic [31:0] expd;
    if (!resetn) begin
      sl_q.delete();
      r_beat = 0;
      arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
    end else begin
      if (s_arvalid) arvalid_seen = 1;
      if (s_arvalid && s_rready) overlap = 1;
      if (s_arvalid && s_arready) begin
        got  = {s_araddr, 32'(s_arlen) + 32'd1};
        want = (exp_ar.size() > 0) ? exp_ar.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check("ar_addr_len", got, want);
        sl_q.push_back(got);
      end
      if (s_rvalid && s_rready && sl_q.size() > 0) begin
        beats_seen++;
        job_beat++;
        r_beat++;
        if (r_beat == int'(sl_q[0][31:0])) begin
          void'(sl_q.pop_front());
          r_beat = 0;
        end
      end
      if (s_dvalid && s_next) begin
        expd = (exp_q.size() > 0) ? exp_q.pop_front() : ~s_data;
        check("pop_data", 64'(s_data), 64'(expd));
      end
      case (ar_mode)
        0:       arready = 1;
        1:       arready = ($urandom_range(0, 1) == 1);
        default: arready = 0;
      endcase
      if (sl_q.size() > 0 && ((s_rvalid && !s_rready) || $urandom_range(0, 3) != 0)) begin
        rvalid = 1;
        rdata  = mem_word(sl_q[0][63:32] + 32'(4 * r_beat));
        rlast  = (r_beat == int'(sl_q[0][31:0]) - 1) || (job_beat == inj_last);
        rresp  = (job_beat == inj_resp) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0; rlast = 0; rresp = 0;
      end
      case (next_mode)
        0:       next = 1;
        1:       next = ($urandom_range(0, 1) == 1);
        default: next = 0;
      endcase
    end
    s_arvalid = arvalid_o; s_arready = arready; s_araddr = araddr_o; s_arlen = arlen_o;
    s_rvalid = rvalid; s_rready = rready_o; s_dvalid = dvalid_o; s_next = next; s_data = data_o;
  end

  task automatic start_job(input vec_t v);
    @(negedge clk);
    #2;
    build_model(v.addr, v.len);
    ar_mode = v.ar_mode; next_mode = v.next_mode;
    inj_resp = v.resp_beat; inj_last = v.last_beat;
    beats_seen = 0; job_beat = 0; arvalid_seen = 0; overlap = 0;
    address = v.addr; length = v.len;
    start = 1;
  endtask

  task automatic wait_end(input int budget, output int cycles);
    cycles = 0;
    while (!(done_o || error_o) && cycles < budget) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    check("job_ended", 64'(done_o || error_o), 64'd1);
  endtask

  task automatic clear_tb_state();
    sl_q.delete(); exp_q.delete(); exp_ar.delete();
    r_beat = 0; rvalid = 0; rlast = 0; rresp = 0;
    inj_resp = -1; inj_last = -1;
  endtask

  task automatic finish_job(input vec_t v, input int cycles);
    check("error_type", 64'(err_type_o), 64'(v.exp_type));
    check("done", 64'(done_o), 64'(v.exp_type == 0));
    check("error", 64'(error_o), 64'(v.exp_type != 0));
    check("data_valid_end", 64'(dvalid_o), 64'd0);
    check("ar_r_overlap", 64'(overlap), 64'd0);
    check("ar_const", {arid_o, arsize_o, arburst_o, arlock_o, arcache_o, arprot_o, arqos_o},
          {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
    if (v.exp_type == 0) begin
      check("words_left", 64'(exp_q.size()), 64'd0);
      check("bursts_left", 64'(exp_ar.size()), 64'd0);
    end
    if (v.exp_type == 1 || v.exp_type == 2) check("arvalid_seen", 64'(arvalid_seen), 64'd0);
    if (v.exp_type == 3) check("timeout_window", 64'(cycles >= 256 && cycles <= 262), 64'd1);
    start = 0;
    repeat (2) @(negedge clk);
    #2;
    check("back_to_idle", {done_o, error_o, arvalid_o, rready_o}, 4'b0000);
    clear_tb_state();
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] l, input int am,
                              input int nm, input int rb, input int lb, input logic [2:0] et);
    vec_t v;
    v.addr = a; v.len = l; v.ar_mode = am; v.next_mode = nm;
    v.resp_beat = rb; v.last_beat = lb; v.exp_type = et;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t v;
    int cyc;
    vecs.push_back(mk(32'h0000_1000, 40, 0, 0, -1, -1, 3'd0));
    vecs.push_back(mk(32'h0000_1FF8, 10, 0, 0, -1, -1, 3'd0));
    vecs.push_back(mk(32'h0000_1002,  5, 0, 0, -1, -1, 3'd1));
    vecs.push_back(mk(32'h0000_2000,  0, 0, 0, -1, -1, 3'd2));
    vecs.push_back(mk(32'h0000_3000, 20, 0, 1,  3, -1, 3'd4));
    vecs.push_back(mk(32'h0000_4000, 20, 0, 1, -1,  4, 3'd5));
    vecs.push_back(mk(32'h0000_8000,  3, 2, 0, -1, -1, 3'd3));
    vecs.push_back(mk(32'hFFFF_FFF8,  2, 1, 1, -1, -1, 3'd0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk((32'($urandom_range(1, 7)) << 12) - 32'(4 * $urandom_range(0, 40)),
                        32'($urandom_range(1, 60)), 1, 1, -1, -1, 3'd0));

    resetn = 0; start = 0; next = 0; address = 0; length = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
    #1;
    check("reset_outputs", {arvalid_o, rready_o, done_o, error_o, err_type_o, dvalid_o}, 8'd0);
    repeat (3) @(negedge clk);
    resetn = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      start_job(vecs[i]);
      wait_end(3000, cyc);
      finish_job(vecs[i], cyc);
    end

    // Consumer holds off: fetch stops once the FIFO holds two full bursts.
    v = mk(32'h0000_5000, 64, 0, 2, -1, -1, 3'd0);
    start_job(v);
    repeat (300) @(negedge clk);
    #2;
    check("stall_beats", 64'(beats_seen), 64'd32);
    check("stall_not_done", 64'(done_o), 64'd0);
    check("stall_valid", 64'(dvalid_o), 64'd1);
    check("stall_no_ar", 64'(arvalid_o), 64'd0);
    next_mode = 0;
    wait_end(3000, cyc);
    finish_job(v, cyc);

    // Asynchronous reset in the middle of a data burst.
    v = mk(32'h0000_6000, 40, 0, 1, -1, -1, 3'd0);
    start_job(v);
    cyc = 0;
    while (!(beats_seen >= 5 && rready_o) && cyc < 500) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("reached_data", 64'(beats_seen >= 5 && rready_o), 64'd1);
    #1;
    resetn = 0;
    #1;
    check("reset_async", {arvalid_o, rready_o, done_o, error_o, err_type_o, dvalid_o}, 8'd0);
    start = 0;
    repeat (2) @(negedge clk);
    clear_tb_state();
    #2;
    resetn = 1;

    v = vecs[0];
    start_job(v);
    wait_end(3000, cyc);
    finish_job(v, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
